// File: rtl/mem_transfer_engine.sv
// mem_transfer_engine
// Bus master that copies Count 256-bit words from a source unit/offset to a
// destination unit/offset over the shared address bus. Each word takes three
// bus cycles: a read strobe, a wait cycle while the target returns data, then
// a write strobe.
//
// Ports
//   Clk, nReset        clock (rising edge), asynchronous active-low reset
//   Start              single-cycle command strobe, accepted only when idle
//   SrcAddr, DstAddr   {unit[15:12], offset[11:0]} of the first word
//   Count              number of words to copy (0 completes with no bus activity)
//   MemDataOut         read data returned by the addressed unit
//   address            bus address
//   nRead, nWrite      active-low strobes, never low together
//   ExecDataOut        write data, qualified only by nWrite
//   Busy               high while a command is in flight, through the Done cycle
//   Done, Err          one-cycle completion pulse; Err marks an illegal unit code
//
// state   | meaning
// IDLE    | waiting for Start
// RD_REQ  | read strobe for word k is being issued
// RD_WAIT | target is returning read data
// WR      | write strobe for word k is being issued; k advances
// FIN     | Done (and Err) is being issued
//
// All outputs are registered decodes of the current state, so each bus
// phase appears on the pins one cycle after the state that requests it.
// The write data register doubles as the read holding register: it loads
// MemDataOut in the cycle the target presents it.

module mem_transfer_engine #(
   parameter int DATA_W   = 256,
   parameter int ADDR_W   = 16,
   parameter int CNT_W    = 4,
   parameter int MAX_UNIT = 5
) (
   input  logic              Clk,
   input  logic              nReset,
   input  logic              Start,
   input  logic [ADDR_W-1:0] SrcAddr,
   input  logic [ADDR_W-1:0] DstAddr,
   input  logic [CNT_W-1:0]  Count,
   input  logic [DATA_W-1:0] MemDataOut,
   output logic [ADDR_W-1:0] address,
   output logic              nRead,
   output logic              nWrite,
   output logic [DATA_W-1:0] ExecDataOut,
   output logic              Busy,
   output logic              Done,
   output logic              Err
);

   localparam int OFF_W = ADDR_W - 4;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_REQ  = 3'd1;
   localparam logic [2:0] RD_WAIT = 3'd2;
   localparam logic [2:0] WR      = 3'd3;
   localparam logic [2:0] FIN     = 3'd4;

   localparam logic [CNT_W-1:0] K_ONE    = CNT_W'(1);
   localparam logic [3:0]       UNIT_MAX = 4'(MAX_UNIT);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  k_q, k_d;
   logic              err_flag_q, err_flag_d;
   logic [ADDR_W-1:0] address_q, address_d;
   logic              n_read_q, n_read_d;
   logic              n_write_q, n_write_d;
   logic [DATA_W-1:0] exec_data_q, exec_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [OFF_W-1:0]  src_off_k;
   logic [OFF_W-1:0]  dst_off_k;

   // Offsets wrap modulo 4096; the unit nibble is carried through untouched.
   assign src_off_k = src_q[OFF_W-1:0] + OFF_W'(k_q);
   assign dst_off_k = dst_q[OFF_W-1:0] + OFF_W'(k_q);

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      cnt_d       = cnt_q;
      k_d         = k_q;
      err_flag_d  = err_flag_q;
      address_d   = address_q;
      n_read_d    = 1'b1;
      n_write_d   = 1'b1;
      exec_data_d = exec_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            // busy_q is still high during the Done cycle; a Start there is dropped.
            if (Start && !busy_q) begin
               src_d = SrcAddr;
               dst_d = DstAddr;
               cnt_d = Count;
               k_d   = '0;
               if ((SrcAddr[ADDR_W-1 -: 4] > UNIT_MAX) ||
                   (DstAddr[ADDR_W-1 -: 4] > UNIT_MAX)) begin
                  err_flag_d = 1'b1;
                  state_d    = FIN;
               end else if (Count == '0) begin
                  err_flag_d = 1'b0;
                  state_d    = FIN;
               end else begin
                  err_flag_d = 1'b0;
                  state_d    = RD_REQ;
               end
            end
         end
         RD_REQ: begin
            address_d = {src_q[ADDR_W-1 -: 4], src_off_k};
            n_read_d  = 1'b0;
            state_d   = RD_WAIT;
         end
         RD_WAIT: begin
            state_d = WR;
         end
         WR: begin
            // MemDataOut is valid now: the target registered it on the edge
            // that ended the read strobe.
            address_d   = {dst_q[ADDR_W-1 -: 4], dst_off_k};
            n_write_d   = 1'b0;
            exec_data_d = MemDataOut;
            k_d         = k_q + K_ONE;
            state_d     = ((k_q + K_ONE) == cnt_q) ? FIN : RD_REQ;
         end
         FIN: begin
            done_d  = 1'b1;
            err_d   = err_flag_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE) || (state_q == FIN);
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q     <= IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         cnt_q       <= '0;
         k_q         <= '0;
         err_flag_q  <= 1'b0;
         address_q   <= '0;
         n_read_q    <= 1'b1;
         n_write_q   <= 1'b1;
         exec_data_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         err_flag_q  <= err_flag_d;
         address_q   <= address_d;
         n_read_q    <= n_read_d;
         n_write_q   <= n_write_d;
         exec_data_q <= exec_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign address     = address_q;
   assign nRead       = n_read_q;
   assign nWrite      = n_write_q;
   assign ExecDataOut = exec_data_q;
   assign Busy        = busy_q;
   assign Done        = done_q;
   assign Err         = err_q;

endmodule

// File: tb/tb_mem_transfer_engine.sv
// Bench for mem_transfer_engine: a registered-read memory model answers the
// bus, a monitor logs every strobe and Done pulse, and each command is compared
// against a word-by-word copy computed on a shadow of the memory contents.

module tb_mem_transfer_engine;

   logic         Clk = 1'b0;
   logic         nReset = 1'b0;
   logic         Start = 1'b0;
   logic [15:0]  SrcAddr = '0;
   logic [15:0]  DstAddr = '0;
   logic [3:0]   Count = '0;
   logic [255:0] MemDataOut = '0;
   logic [15:0]  address;
   logic         nRead;
   logic         nWrite;
   logic [255:0] ExecDataOut;
   logic         Busy;
   logic         Done;
   logic         Err;

   mem_transfer_engine dut (
      .Clk(Clk), .nReset(nReset), .Start(Start), .SrcAddr(SrcAddr),
      .DstAddr(DstAddr), .Count(Count), .MemDataOut(MemDataOut),
      .address(address), .nRead(nRead), .nWrite(nWrite),
      .ExecDataOut(ExecDataOut), .Busy(Busy), .Done(Done), .Err(Err)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   logic [255:0] mem [logic [15:0]];

   function automatic logic [255:0] def_word(input logic [15:0] a);
      return {8{a, ~a}};
   endfunction

   // Shared-bus target: registers read data on the edge that samples nRead low.
   always @(posedge Clk) begin
      if (nRead === 1'b0) MemDataOut <= mem.exists(address) ? mem[address] : def_word(address);
      if (nWrite === 1'b0) mem[address] = ExecDataOut;
   end

   logic [15:0]  rd_q[$];
   logic [15:0]  wa_q[$];
   logic [255:0] wd_q[$];
   int           rc_q[$];
   int           wc_q[$];
   int           dl_q[$];
   logic         de_q[$];
   int           overlap = 0;
   int           start_cyc = 0;

   always @(negedge Clk) begin
      if (nRead === 1'b0) begin rd_q.push_back(address); rc_q.push_back(cyc); end
      if (nWrite === 1'b0) begin
         wa_q.push_back(address); wd_q.push_back(ExecDataOut); wc_q.push_back(cyc);
      end
      if (nRead === 1'b0 && nWrite === 1'b0) overlap++;
      if (Done === 1'b1) begin dl_q.push_back(cyc - start_cyc + 1); de_q.push_back(Err); end
   end

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      rd_q.delete(); wa_q.delete(); wd_q.delete(); rc_q.delete();
      wc_q.delete(); dl_q.delete(); de_q.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " address"}, address, 16'h0000);
      check({tag, " nRead"}, nRead, 1'b1);
      check({tag, " nWrite"}, nWrite, 1'b1);
      check({tag, " ExecDataOut"}, ExecDataOut, '0);
      check({tag, " Busy"}, Busy, 1'b0);
      check({tag, " Done"}, Done, 1'b0);
      check({tag, " Err"}, Err, 1'b0);
   endtask

   task automatic run_cmd(input string tag, input logic [15:0] src, input logic [15:0] dst,
                          input logic [3:0] n, input bit poke_busy);
      logic [255:0] shadow [logic [15:0]];
      logic [15:0]  e_rd[$];
      logic [15:0]  e_wa[$];
      logic [255:0] e_wd[$];
      bit           e_err;
      int           e_lat;
      int           nr;
      int           nw;
      shadow = mem;
      e_err = (src[15:12] > 4'd5) || (dst[15:12] > 4'd5);
      if (!e_err) begin
         for (int i = 0; i < int'(n); i++) begin
            logic [15:0]  ra;
            logic [15:0]  wa;
            logic [255:0] d;
            ra = {src[15:12], 12'(src[11:0] + i)};
            wa = {dst[15:12], 12'(dst[11:0] + i)};
            d  = shadow.exists(ra) ? shadow[ra] : def_word(ra);
            shadow[wa] = d;
            e_rd.push_back(ra); e_wa.push_back(wa); e_wd.push_back(d);
         end
      end
      e_lat = (e_err || n == 0) ? 2 : 3 * int'(n) + 2;

      clear_logs();
      @(negedge Clk);
      SrcAddr = src; DstAddr = dst; Count = n; Start = 1'b1;
      @(posedge Clk);
      #1;
      start_cyc = cyc;
      Start = 1'b0;
      if (poke_busy) begin
         repeat (3) @(negedge Clk);
         SrcAddr = 16'($urandom); DstAddr = 16'($urandom);
         Count = 4'($urandom_range(1, 15)); Start = 1'b1;
         @(negedge Clk);
         Start = 1'b0; SrcAddr = 16'($urandom); DstAddr = 16'($urandom);
      end
      repeat (e_lat + (poke_busy ? 40 : 6)) @(negedge Clk);
      #1;

      check({tag, " done pulses"}, dl_q.size(), 1);
      if (dl_q.size() > 0) begin
         check({tag, " latency"}, dl_q[0], e_lat);
         check({tag, " err"}, de_q[0], e_err);
      end
      check({tag, " read count"}, rd_q.size(), e_rd.size());
      check({tag, " write count"}, wa_q.size(), e_wa.size());
      nr = (rd_q.size() < e_rd.size()) ? rd_q.size() : e_rd.size();
      nw = (wa_q.size() < e_wa.size()) ? wa_q.size() : e_wa.size();
      for (int i = 0; i < nr; i++) begin
         check($sformatf("%s rd addr %0d", tag, i), rd_q[i], e_rd[i]);
         check($sformatf("%s rd cycle %0d", tag, i), rc_q[i] - start_cyc, 1 + 3 * i);
      end
      for (int i = 0; i < nw; i++) begin
         check($sformatf("%s wr addr %0d", tag, i), wa_q[i], e_wa[i]);
         check($sformatf("%s wr data %0d", tag, i), wd_q[i], e_wd[i]);
         check($sformatf("%s wr cycle %0d", tag, i), wc_q[i] - start_cyc, 3 + 3 * i);
      end
      check({tag, " busy after"}, Busy, 1'b0);
      check({tag, " done after"}, Done, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge Clk);
      check_idle_outputs("por");
      nReset = 1'b1;
      repeat (2) @(negedge Clk);
      check_idle_outputs("idle");

      mem[16'h0002] = {32{8'hA5}};
      run_cmd("single", 16'h0002, 16'h1005, 4'd1, 1'b0);
      check("single mem", mem[16'h1005], {32{8'hA5}});

      mem[16'h0000] = {32{8'h11}};
      mem[16'h0001] = {32{8'h22}};
      mem[16'h0002] = {32{8'h33}};
      mem[16'h0003] = {32{8'h44}};
      run_cmd("burst4", 16'h0000, 16'h3000, 4'd4, 1'b0);

      run_cmd("wrap", 16'h0FFE, 16'h2010, 4'd3, 1'b0);
      run_cmd("bad_src", 16'h7000, 16'h1000, 4'd2, 1'b0);
      run_cmd("bad_dst", 16'h1000, 16'h6000, 4'd2, 1'b0);
      run_cmd("zero", 16'h0010, 16'h1010, 4'd0, 1'b0);
      run_cmd("overlap", 16'h4100, 16'h4101, 4'd5, 1'b0);
      run_cmd("max", 16'h5FF8, 16'h0FFC, 4'd15, 1'b0);
      run_cmd("busy_start", 16'h0100, 16'h2200, 4'd3, 1'b1);

      for (int t = 0; t < 8; t++) begin
         logic [15:0] s;
         logic [15:0] d;
         s[15:12] = 4'($urandom_range(0, 6));
         d[15:12] = 4'($urandom_range(0, 6));
         s[11:0]  = ($urandom_range(0, 1) == 1) ? 12'hFF0 + 12'($urandom_range(0, 15)) : 12'($urandom);
         d[11:0]  = 12'($urandom);
         run_cmd($sformatf("rand%0d", t), s, d, 4'($urandom_range(0, 15)), 1'b0);
      end

      // Asynchronous reset in the middle of a write strobe.
      clear_logs();
      @(negedge Clk);
      SrcAddr = 16'h0200; DstAddr = 16'h1200; Count = 4'd3; Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      for (int i = 0; i < 20 && nWrite !== 1'b0; i++) @(negedge Clk);
      check("rst reached write", nWrite, 1'b0);
      #2 nReset = 1'b0;
      Start = 1'b1;
      #1 check_idle_outputs("rst async");
      repeat (3) @(negedge Clk) Start = ~Start;
      check_idle_outputs("rst held");
      Start = 1'b0;
      @(negedge Clk) nReset = 1'b1;
      clear_logs();
      repeat (30) @(negedge Clk);
      check("rst no write", wa_q.size(), 0);
      check("rst no read", rd_q.size(), 0);
      check("rst no done", dl_q.size(), 0);
      check_idle_outputs("rst after");

      run_cmd("post_rst", 16'h0003, 16'h1003, 4'd2, 1'b0);
      check("strobe overlap", overlap, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
